holy_clint: RTL
===============

# holy_clint

Core-local interruptor for the HOLY CORE SoC: drives the `timer_itr` and `soft_itr` inputs of the core's CSR file. It holds a free-running 64-bit `mtime`, a 64-bit `mtimecmp` and a software-interrupt bit `msip`. All three are memory-mapped behind an AXI4-Lite slave port on the SoC interconnect. It is the interrupt-source end of the CSR file's `mip` sampling path.

## Interface
- `TICK_DIV`, default 1: clock cycles per `mtime` increment; legal range ≥1.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `s_axi_awaddr`  in  32, `s_axi_awvalid` in 1, `s_axi_awready` out 1: write address channel.
- `s_axi_wdata`  in  32, `s_axi_wstrb` in 4, `s_axi_wvalid` in 1, `s_axi_wready` out 1: write data channel.
- `s_axi_bresp`  out  2, `s_axi_bvalid` out 1, `s_axi_bready` in 1: write response channel.
- `s_axi_araddr`  in  32, `s_axi_arvalid` in 1, `s_axi_arready` out 1: read address channel.
- `s_axi_rdata`  out  32, `s_axi_rresp` out 2, `s_axi_rvalid` out 1, `s_axi_rready` in 1: read data channel.
- `timer_itr`  out  1  level, high while `mtime >= mtimecmp`.
- `soft_itr`  out  1  level, equals `msip[0]`.

## Operation
- Register map, decoded on `addr[15:0]`, word-aligned:
  - 0x0000 `msip`: bit 0 is writable; other bits read 0.
  - 0x4000 / 0x4004: `mtimecmp` low / high.
  - 0xBFF8 / 0xBFFC: `mtime` low / high.
- Unmapped reads return 0. Unmapped writes are dropped. `bresp` and `rresp` are always OKAY (2'b00).
- `wstrb` is honoured per byte on every register.
- Reset values: `mtime` = 0, `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF, `msip` = 0, prescaler counter = 0.
- `mtime` increments by 1 when the prescaler counter reaches `TICK_DIV-1`; the counter then returns to 0. With `TICK_DIV`=1, `mtime` increments every cycle. `mtime` wraps 2^64-1 → 0 silently.
- Bus FSM, one outstanding transaction:
  - IDLE: `awready` = `wready` = 1 only when `awvalid && wvalid`, and both handshake in the same cycle. Otherwise `arready` = 1 when `arvalid`. Write wins if both are pending.
  - After a write handshake → WRESP: `bvalid` = 1; hold until `bready`, then → IDLE.
  - After a read handshake → RRESP: `rvalid` = 1 and `rdata` is held stable; hold until `rready`, then → IDLE.
- Write vs. tick in the same cycle: the software write wins on the written word. The other 32-bit half still takes the increment's value, computed from the pre-write `mtime`.
- Writing one half of `mtimecmp`/`mtime` updates only that half; no atomicity is provided. Software writes `mtimecmp` hi = all-ones first.

## Timing
- All outputs are registered.
- Output reset values: all `*ready` = 0, `bvalid` = 0, `rvalid` = 0, `rdata` = 0, `bresp` = `rresp` = 0, `timer_itr` = 0, `soft_itr` = 0.
- Write handshake at edge N: the register holds the new value after edge N, and `bvalid` = 1 in cycle N+1.
- Read handshake at edge N: `rdata` is sampled from the register values at edge N, and `rvalid` = 1 in cycle N+1.
- `timer_itr` is registered from the comparison of the current `mtime`/`mtimecmp`, giving one cycle of latency after either changes.
- `soft_itr` changes in the cycle after the `msip` write edge.
- Minimum transaction period is 2 cycles; back-to-back handshakes are possible when `bready`/`rready` are held high.
- Reset mid-transaction: the FSM returns to IDLE and any pending response is lost.

## Structure
- The shared SoC package holds:
  - the address constants `CLINT_MSIP`, `CLINT_MTIMECMP_LO/HI`, `CLINT_MTIME_LO/HI`;
  - a `clint_state_t` enum {IDLE, WRESP, RRESP};
  - the AXI response constant `AXI_OKAY`.
- Sub-module `clint_byte_write`: merges a 32-bit word with `wdata` under `wstrb`. It is combinational and reused for all five register writes.
- Everything else, including the FSM, counters and comparison, stays in `holy_clint`.

## Test plan
- Reset, then idle for 10 cycles, with `TICK_DIV`=1 → `mtime` reads back 0x0A ±bus latency; `timer_itr` = 0; `mtimecmp` reads all-ones.
- Write `mtimecmp` hi = 0, then lo = 0x20 → `timer_itr` rises exactly one cycle after `mtime` reaches 0x20. Then write `mtimecmp` lo = 0xFFFF_FFFF → `timer_itr` falls one cycle after the write.
- Write 0x1 to 0x0000 → `soft_itr` = 1 in the next cycle. Write 0x0 → `soft_itr` = 0. A read of 0x0000 with `wdata` 0xFFFF_FFFF written returns 0x1.
- Write `mtime` lo = 0xFFFF_FFFF with `TICK_DIV`=1 → the high half increments by 1 two cycles later. A write with `wstrb` = 4'b0010 changes only byte 1.
- Stall the master: hold `bready` = 0 for 5 cycles → `bvalid` and FSM held; no new AW/AR accepted. Assert AR and AW/W in the same cycle → write completes first, then read.
- Read 0x1234 → `rdata` = 0, `rresp` = OKAY. Write 0x1234 → no register changes. Assert reset during RRESP → `rvalid` = 0 on the next cycle.

Source files
------------

// File: rtl/holy_clint_pkg.sv
// Shared definitions for the HOLY CORE core-local interruptor: register
// addresses, bus FSM states and AXI response codes.
package holy_clint_pkg;

    localparam logic [15:0] CLINT_MSIP        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

    localparam logic [1:0] AXI_OKAY = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRESP = 2'd1,
        RRESP = 2'd2
    } clint_state_t;

endpackage

// File: rtl/holy_clint_if.sv
// AXI4-Lite bundle between the SoC interconnect (master) and the CLINT (slave).
interface holy_clint_if;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/holy_clint_byte_write.sv
// Byte-lane merge of write data into an existing 32-bit register word.
module clint_byte_write (
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] new_word
);

    always_comb begin
        new_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
                new_word[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/holy_clint.sv
// Core-local interruptor: prescaled 64-bit mtime, mtimecmp and msip behind an
// AXI4-Lite slave, producing level timer/software interrupts.
//
//   state | meaning
//   IDLE  | no transaction in flight; ready raised for the next AW+W or AR
//   WRESP | write committed, bvalid held until bready
//   RRESP | read data captured, rvalid held until rready
module holy_clint
    import holy_clint_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    holy_clint_if.slave s_axi,
    output logic        timer_itr,
    output logic        soft_itr
);

    localparam int unsigned      CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    clint_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      mtime_q, mtime_d;
    logic [63:0]      mtimecmp_q, mtimecmp_d;
    logic             msip_q, msip_d;
    logic             awready_q, awready_d;
    logic             arready_q, arready_d;
    logic             bvalid_q, bvalid_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             timer_itr_q, timer_itr_d;
    logic             soft_itr_q, soft_itr_d;

    logic        wr_hs, rd_hs, aw_pend, tick;
    logic [13:0] wr_word, rd_word;
    logic [31:0] msip_new, cmp_lo_new, cmp_hi_new, mt_lo_new, mt_hi_new;
    logic        unused_bits;

    assign wr_word = s_axi.awaddr[15:2];
    assign rd_word = s_axi.araddr[15:2];

    assign unused_bits = ^{s_axi.awaddr[31:16], s_axi.awaddr[1:0],
                           s_axi.araddr[31:16], s_axi.araddr[1:0], msip_new[31:1]};

    clint_byte_write u_bw_msip (
        .old_word ({31'b0, msip_q}),
        .wdata    (s_axi.wdata),
        .wstrb    (s_axi.wstrb),
        .new_word (msip_new)
    );

    clint_byte_write u_bw_cmp_lo (
        .old_word (mtimecmp_q[31:0]),
        .wdata    (s_axi.wdata),
        .wstrb    (s_axi.wstrb),
        .new_word (cmp_lo_new)
    );

    clint_byte_write u_bw_cmp_hi (
        .old_word (mtimecmp_q[63:32]),
        .wdata    (s_axi.wdata),
        .wstrb    (s_axi.wstrb),
        .new_word (cmp_hi_new)
    );

    clint_byte_write u_bw_mt_lo (
        .old_word (mtime_q[31:0]),
        .wdata    (s_axi.wdata),
        .wstrb    (s_axi.wstrb),
        .new_word (mt_lo_new)
    );

    clint_byte_write u_bw_mt_hi (
        .old_word (mtime_q[63:32]),
        .wdata    (s_axi.wdata),
        .wstrb    (s_axi.wstrb),
        .new_word (mt_hi_new)
    );

    always_comb begin
        // Ready is only ever raised while idle, so these are true handshakes.
        wr_hs   = awready_q && s_axi.awvalid && s_axi.wvalid;
        rd_hs   = arready_q && s_axi.arvalid;
        aw_pend = s_axi.awvalid && s_axi.wvalid;

        tick    = (cnt_q == CNT_LAST);
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;

        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;

        // A write overrides only its own half; the other keeps the tick result.
        if (wr_hs) begin
            case (wr_word)
                CLINT_MSIP[15:2]:        msip_d             = msip_new[0];
                CLINT_MTIMECMP_LO[15:2]: mtimecmp_d[31:0]   = cmp_lo_new;
                CLINT_MTIMECMP_HI[15:2]: mtimecmp_d[63:32]  = cmp_hi_new;
                CLINT_MTIME_LO[15:2]:    mtime_d[31:0]      = mt_lo_new;
                CLINT_MTIME_HI[15:2]:    mtime_d[63:32]     = mt_hi_new;
                default: ;
            endcase
        end

        rdata_d = rdata_q;
        if (rd_hs) begin
            case (rd_word)
                CLINT_MSIP[15:2]:        rdata_d = {31'b0, msip_q};
                CLINT_MTIMECMP_LO[15:2]: rdata_d = mtimecmp_q[31:0];
                CLINT_MTIMECMP_HI[15:2]: rdata_d = mtimecmp_q[63:32];
                CLINT_MTIME_LO[15:2]:    rdata_d = mtime_q[31:0];
                CLINT_MTIME_HI[15:2]:    rdata_d = mtime_q[63:32];
                default:                 rdata_d = 32'h0;
            endcase
        end

        state_d  = state_q;
        bvalid_d = bvalid_q;
        rvalid_d = rvalid_q;
        case (state_q)
            IDLE: begin
                if (wr_hs) begin
                    state_d  = WRESP;
                    bvalid_d = 1'b1;
                end else if (rd_hs) begin
                    state_d  = RRESP;
                    rvalid_d = 1'b1;
                end
            end
            WRESP: begin
                if (s_axi.bready) begin
                    state_d  = IDLE;
                    bvalid_d = 1'b0;
                end
            end
            RRESP: begin
                if (s_axi.rready) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                bvalid_d = 1'b0;
                rvalid_d = 1'b0;
            end
        endcase

        // Readies look at the next state so a response retiring this cycle
        // can be followed by a handshake on the very next edge.
        awready_d = (state_d == IDLE) && aw_pend;
        arready_d = (state_d == IDLE) && !aw_pend && s_axi.arvalid;

        timer_itr_d = (mtime_q >= mtimecmp_q);
        soft_itr_d  = msip_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mtime_q     <= 64'h0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_q      <= 1'b0;
            awready_q   <= 1'b0;
            arready_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'h0;
            timer_itr_q <= 1'b0;
            soft_itr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            awready_q   <= awready_d;
            arready_q   <= arready_d;
            bvalid_q    <= bvalid_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            timer_itr_q <= timer_itr_d;
            soft_itr_q  <= soft_itr_d;
        end
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = awready_q;
    assign s_axi.arready = arready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.bresp   = AXI_OKAY;
    assign s_axi.rresp   = AXI_OKAY;
    assign timer_itr     = timer_itr_q;
    assign soft_itr      = soft_itr_q;

endmodule
